scd_intr_ctrl: RTL and testbench

//  Interrupt sequencer and port arbiter in front of the 32x32 scd_intr RAM
//  (combinational read, write on posedge clk). Latches IRQ edges, picks the

---
 rtl/scd_intr_ctrl.sv | 172 +++++++++++++++++
 tb/tb_scd_intr_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scd_intr_ctrl.sv
// Interrupt sequencer and RAM-port arbiter for the scd_intr RAM.
// Optional per-line masking (mask register at RAM word 5'h1f) when SCD_INTR_MASK_EN is defined.
module scd_intr_ctrl #(
    parameter int NIRQ       = 4,
    parameter int VEC_BASE   = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [NIRQ-1:0] irq,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [31:0]     cpu_addr,
    input  logic [31:0]     cpu_din,
    output logic [31:0]     cpu_dout,
    output logic            cpu_stall,
    output logic [31:0]     ram_addr,
    output logic            ram_we,
    output logic [31:0]     ram_din,
    input  logic [31:0]     ram_dout,
    output logic            intr,
    input  logic            inta,
    input  logic            eoi,
    output logic [31:0]     vector,
    output logic [2:0]      irq_id
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [4:0] VEC_BASE_W = 5'(VEC_BASE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        SERVICE = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [NIRQ-1:0] pending_reg, pending_next;
    logic [NIRQ-1:0] irq_q_reg;
    logic [NIRQ-1:0] eligible;
    logic [SW-1:0]   starve_reg, starve_next;
    logic [31:0]     vector_reg, vector_next;
    logic [2:0]      irq_id_reg, irq_id_next;
    logic            intr_reg, intr_next;
    logic [2:0]      sel;
    logic            any_eligible;
    logic            fetch_grant;
    logic            ack;
    logic [4:0]      vec_word;

    assign ack = (state_reg == PRESENT) && inta;

    // A new rising edge on a line takes precedence over its acknowledge.
    genvar gi;
    generate
        for (gi = 0; gi < NIRQ; gi++) begin : g_line
            logic rise;
            logic clear;
            assign rise  = irq[gi] & ~irq_q_reg[gi];
            assign clear = ack && (irq_id_reg == 3'(gi));
            assign pending_next[gi] = rise | (pending_reg[gi] & ~clear);
        end
    endgenerate

`ifdef SCD_INTR_MASK_EN
    localparam logic [4:0] MASK_WORD = 5'h1f;
    logic [NIRQ-1:0] mask_reg;
    logic            mask_wr;

    assign mask_wr  = !fetch_grant && cpu_req && cpu_we && (cpu_addr[6:2] == MASK_WORD);
    assign eligible = pending_reg & ~mask_reg;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mask_reg <= '0;
        end else if (mask_wr) begin
            mask_reg <= cpu_din[NIRQ-1:0];
        end
    end
`else
    assign eligible = pending_reg;
`endif

    // Fixed priority: lowest index wins.
    always_comb begin
        sel          = '0;
        any_eligible = 1'b0;
        for (int n = NIRQ - 1; n >= 0; n--) begin
            if (eligible[n]) begin
                sel          = 3'(n);
                any_eligible = 1'b1;
            end
        end
    end

    assign vec_word = VEC_BASE_W + {2'b00, sel};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            irq_q_reg   <= '0;
            starve_reg  <= '0;
            vector_reg  <= '0;
            irq_id_reg  <= '0;
            intr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            irq_q_reg   <= irq;
            starve_reg  <= starve_next;
            vector_reg  <= vector_next;
            irq_id_reg  <= irq_id_next;
            intr_reg    <= intr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        starve_next = starve_reg;
        vector_next = vector_reg;
        irq_id_next = irq_id_reg;
        intr_next   = intr_reg;
        fetch_grant = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_eligible) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                // Lines masked while waiting for the port send us back to IDLE.
                if (!any_eligible) begin
                    state_next  = IDLE;
                    starve_next = '0;
                end else if (cpu_req && (starve_reg < SW'(STARVE_MAX))) begin
                    starve_next = starve_reg + SW'(1);
                end else begin
                    fetch_grant = 1'b1;
                    vector_next = ram_dout;
                    irq_id_next = sel;
                    starve_next = '0;
                    intr_next   = 1'b1;
                    state_next  = PRESENT;
                end
            end
            PRESENT: begin
                if (inta) begin
                    intr_next  = 1'b0;
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ram_addr  = fetch_grant ? {25'b0, vec_word, 2'b00} : cpu_addr;
    assign ram_we    = fetch_grant ? 1'b0 : (cpu_req & cpu_we);
    assign ram_din   = cpu_din;
    assign cpu_dout  = ram_dout;
    assign cpu_stall = fetch_grant & cpu_req;
    assign intr      = intr_reg;
    assign vector    = vector_reg;
    assign irq_id    = irq_id_reg;

endmodule

// File: tb/tb_scd_intr_ctrl.sv
// Bench for scd_intr_ctrl: directed scenarios then random IRQ/CPU traffic checked
// against a set-of-pending-lines reference and a RAM image.
module tb_scd_intr_ctrl;

    localparam int NIRQ       = 4;
    localparam int VEC_BASE   = 8;
    localparam int STARVE_MAX = 3;
    localparam int MAX_LAT    = 2 + STARVE_MAX + 1;

    logic            clk = 1'b0;
    logic            clrn;
    logic [NIRQ-1:0] irq;
    logic            cpu_req;
    logic            cpu_we;
    logic [31:0]     cpu_addr;
    logic [31:0]     cpu_din;
    logic [31:0]     cpu_dout;
    logic            cpu_stall;
    logic [31:0]     ram_addr;
    logic            ram_we;
    logic [31:0]     ram_din;
    logic [31:0]     ram_dout;
    logic            intr;
    logic            inta;
    logic            eoi;
    logic [31:0]     vector;
    logic [2:0]      irq_id;

    always #5 clk = ~clk;

    scd_intr_ctrl #(
        .NIRQ      (NIRQ),
        .VEC_BASE  (VEC_BASE),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .clrn     (clrn),
        .irq      (irq),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .cpu_stall(cpu_stall),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .intr     (intr),
        .inta     (inta),
        .eoi      (eoi),
        .vector   (vector),
        .irq_id   (irq_id)
    );

    // The 32x32 scd_intr RAM: combinational read, write on posedge.
    logic [31:0] mem [32] = '{8: 32'h30, 9: 32'h3c, 10: 32'h54, 11: 32'h68, default: 32'hc0de_0000};
    assign ram_dout = mem[ram_addr[6:2]];
    always @(posedge clk) if (ram_we) mem[ram_addr[6:2]] <= ram_din;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [31:0]     ref_mem [32];
    logic [NIRQ-1:0] ref_pend = '0;
    logic [NIRQ-1:0] ref_mask = '0;
    int              stall_cnt;
    logic            last_stall;
    logic [31:0]     stall_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [NIRQ-1:0] v);
        for (int i = 0; i < NIRQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic idle_cpu();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    // Random CPU access; writes avoid the vector words and word 5'h1f.
    task automatic rand_cpu();
        logic [4:0] w;
        cpu_req = ($urandom_range(0, 1) == 1);
        cpu_we  = ($urandom_range(0, 2) == 0);
        if (cpu_we) begin
            w = 5'($urandom_range(0, 22));
            if (w >= 5'd8) w = w + 5'd8;
        end else begin
            w = 5'($urandom_range(0, 31));
        end
        cpu_addr = {25'($urandom), w, 2'b00};
        cpu_din  = $urandom;
    endtask

    // One clock cycle: observe the CPU port mid-cycle, then step past the edge.
    task automatic cycle();
        @(negedge clk);
        last_stall = cpu_stall;
        if (cpu_stall) begin
            stall_cnt++;
            stall_addr = ram_addr;
            chk("stall_no_we", 32'(ram_we), 32'h0);
        end
        if (!cpu_req) begin
            chk("no_req_no_stall", 32'(cpu_stall), 32'h0);
        end else if (!cpu_stall) begin
            if (cpu_we) begin
                ref_mem[cpu_addr[6:2]] = cpu_din;
`ifdef SCD_INTR_MASK_EN
                if (cpu_addr[6:2] == 5'h1f) ref_mask = cpu_din[NIRQ-1:0];
`endif
            end else begin
                chk("cpu_read", cpu_dout, ref_mem[cpu_addr[6:2]]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_intr(input bit rnd, output int lat);
        lat        = 0;
        stall_cnt  = 0;
        last_stall = 1'b0;
        while (!intr && lat < MAX_LAT + 2) begin
            if (rnd) rand_cpu();
            cycle();
            lat++;
        end
        chk("intr_arrives", 32'(intr), 32'h1);
        chk("latency_bound", 32'(lat <= MAX_LAT), 32'h1);
        chk("stall_at_most_once", 32'(stall_cnt <= 1), 32'h1);
        if (stall_cnt == 1) chk("stall_on_grant", 32'(last_stall), 32'h1);
        idle_cpu();
    endtask

    // Full handshake for the next interrupt the reference says must be served.
    task automatic present_and_ack(input bit rnd);
        int lat;
        int exp_id;
        int l;
        exp_id = lowest(ref_pend & ~ref_mask);
        wait_intr(rnd, lat);
        chk("irq_id", 32'(irq_id), 32'(exp_id));
        chk("vector", vector, ref_mem[VEC_BASE + exp_id]);
        $display("intr id=%0d vector=%h latency=%0d", irq_id, vector, lat);
        repeat ($urandom_range(0, 2)) begin
            if (rnd) rand_cpu();
            cycle();
            chk("intr_held", 32'(intr), 32'h1);
        end
        idle_cpu();
        inta = 1'b1;
        cycle();
        inta = 1'b0;
        ref_pend[exp_id] = 1'b0;
        chk("intr_cleared", 32'(intr), 32'h0);
        chk("vector_in_service", vector, ref_mem[VEC_BASE + exp_id]);
        repeat ($urandom_range(0, 3)) begin
            if (rnd && $urandom_range(0, 1) == 1) begin
                l = $urandom_range(0, NIRQ - 1);
                if (!irq[l]) begin
                    irq[l]      = 1'b1;
                    ref_pend[l] = 1'b1;
                end
            end
            if (rnd) rand_cpu();
            cycle();
            chk("no_intr_in_service", 32'(intr), 32'h0);
        end
        idle_cpu();
        eoi = 1'b1;
        cycle();
        eoi = 1'b0;
    endtask

    initial begin
        int lat;
        ref_mem  = '{8: 32'h30, 9: 32'h3c, 10: 32'h54, 11: 32'h68, default: 32'hc0de_0000};
        clrn     = 1'b1;
        irq      = '0;
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = '0;
        cpu_din  = '0;
        inta     = 1'b0;
        eoi      = 1'b0;
        #1 clrn = 1'b0;
        #1;
        chk("rst_intr", 32'(intr), 32'h0);
        chk("rst_stall", 32'(cpu_stall), 32'h0);
        chk("rst_vector", vector, 32'h0);
        chk("rst_irq_id", 32'(irq_id), 32'h0);
        repeat (2) cycle();
        clrn = 1'b1;
        cycle();

        // irq[0] alone, with stray eoi in PRESENT and stray inta in SERVICE
        irq[0] = 1'b1;
        ref_pend[0] = 1'b1;
        wait_intr(1'b0, lat);
        chk("t1_latency_le3", 32'(lat <= 3), 32'h1);
        chk("t1_vector", vector, 32'h30);
        chk("t1_irq_id", 32'(irq_id), 32'h0);
        $display("intr id=%0d vector=%h latency=%0d", irq_id, vector, lat);
        eoi = 1'b1;
        cycle();
        eoi = 1'b0;
        chk("t1_eoi_ignored", 32'(intr), 32'h1);
        inta = 1'b1;
        cycle();
        inta = 1'b0;
        ref_pend[0] = 1'b0;
        chk("t1_inta_clears", 32'(intr), 32'h0);
        inta = 1'b1;
        cycle();
        inta = 1'b0;
        eoi = 1'b1;
        cycle();
        eoi = 1'b0;
        repeat (5) begin
            cycle();
            chk("t1_quiet", 32'(intr), 32'h0);
        end

        // irq[1] and irq[3] together: 1 first, then 3
        irq = irq | 4'b1010;
        ref_pend = ref_pend | 4'b1010;
        present_and_ack(1'b0);
        chk("t2_second_pending", 32'(ref_pend), 32'h8);
        present_and_ack(1'b0);

        // irq[2] while the CPU holds the port
        irq = '0;
        cycle();
        irq[2]      = 1'b1;
        ref_pend[2] = 1'b1;
        cpu_req     = 1'b1;
        cpu_we      = 1'b0;
        cpu_addr    = 32'h0000_000c;
        wait_intr(1'b0, lat);
        chk("t3_latency", 32'(lat), 32'(2 + STARVE_MAX + 1));
        chk("t3_stall_count", 32'(stall_cnt), 32'h1);
        chk("t3_fetch_addr", stall_addr, 32'h0000_0028);
        chk("t3_vector", vector, 32'h54);
        chk("t3_irq_id", 32'(irq_id), 32'h2);
        $display("intr id=%0d vector=%h latency=%0d", irq_id, vector, lat);
        inta = 1'b1;
        cycle();
        inta = 1'b0;
        ref_pend[2] = 1'b0;
        eoi = 1'b1;
        cycle();
        eoi = 1'b0;

        // plain RAM write/read through the port
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 32'h0000_0048;
        cpu_din  = 32'h55;
        cycle();
        cpu_we = 1'b0;
        @(negedge clk);
        chk("t6_readback", cpu_dout, 32'h55);
        chk("t6_no_stall", 32'(cpu_stall), 32'h0);
        @(posedge clk);
        #1;
        idle_cpu();
        $display("cpu write/read word 0x12 data=%h", 32'h55);

`ifdef SCD_INTR_MASK_EN
        irq = '0;
        cycle();
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 32'h0000_007c;
        cpu_din  = 32'h1;
        cycle();
        idle_cpu();
        irq[0] = 1'b1;
        ref_pend[0] = 1'b1;
        repeat (6) begin
            cycle();
            chk("t5_masked_quiet", 32'(intr), 32'h0);
        end
        irq[1] = 1'b1;
        ref_pend[1] = 1'b1;
        present_and_ack(1'b0);
        repeat (6) begin
            cycle();
            chk("t5_still_masked", 32'(intr), 32'h0);
        end
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 32'h0000_007c;
        cpu_din  = 32'h0;
        cycle();
        idle_cpu();
        present_and_ack(1'b0);
`endif

        // reset while an interrupt is presented
        irq = '0;
        cycle();
        irq = 4'b0011;
        ref_pend = 4'b0011;
        wait_intr(1'b0, lat);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0;
        clrn = 1'b0;
        #1;
        chk("t4_async_intr", 32'(intr), 32'h0);
        chk("t4_async_stall", 32'(cpu_stall), 32'h0);
        chk("t4_async_vector", vector, 32'h0);
        idle_cpu();
        irq      = '0;
        ref_pend = '0;
        ref_mask = '0;
        cycle();
        clrn = 1'b1;
        repeat (8) begin
            cycle();
            chk("t4_no_intr_after_reset", 32'(intr), 32'h0);
        end
        $display("reset during PRESENT, pending dropped");

        // random rounds: bursts of edges, random CPU traffic, edges during service
        for (int r = 0; r < 30; r++) begin
            irq = '0;
            rand_cpu();
            cycle();
            irq = NIRQ'($urandom_range(1, (1 << NIRQ) - 1));
            ref_pend = ref_pend | irq;
            while (ref_pend != '0) present_and_ack(1'b1);
            repeat (3) begin
                rand_cpu();
                cycle();
                chk("rand_idle_quiet", 32'(intr), 32'h0);
            end
            idle_cpu();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout observed=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
